// File: rtl/muldiv_hilo_if.sv
// Execute-stage port bundle for the multiply/divide + HI/LO unit.
// Valid/ready contract: an op is offered while valid_i=1 and is accepted on the first
// edge where stallreq_o=0; the offerer holds aluop_i/reg1_i/reg2_i stable until then.
interface muldiv_hilo_if #(parameter int DATA_W = 32);
  logic              valid_i;
  logic [7:0]        aluop_i;
  logic [DATA_W-1:0] reg1_i;
  logic [DATA_W-1:0] reg2_i;
  logic              flush_i;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;
  logic              stallreq_o;
  logic              busy_o;
  // Debug visibility of the divider FSM and the MADD phase flag
  logic [1:0]        div_state;
  logic              madd_phase;

  modport master (
    output valid_i, aluop_i, reg1_i, reg2_i, flush_i,
    input  hi_o, lo_o, stallreq_o, busy_o, div_state, madd_phase
  );

  modport slave (
    input  valid_i, aluop_i, reg1_i, reg2_i, flush_i,
    output hi_o, lo_o, stallreq_o, busy_o, div_state, madd_phase
  );
endinterface

// File: rtl/muldiv_hilo.sv
// HI/LO owner for EX: single-cycle MULT/MTHI/MTLO, two-cycle MADD family and a
// 32-step restoring divider that stalls the pipeline while it runs.
module muldiv_hilo (
  input logic          clk,
  input logic          rst,
  muldiv_hilo_if.slave bus
);
  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;
  localparam logic [7:0] EXE_MADD_OP  = 8'b1010_0110;
  localparam logic [7:0] EXE_MADDU_OP = 8'b1010_1000;
  localparam logic [7:0] EXE_MSUB_OP  = 8'b1010_1010;
  localparam logic [7:0] EXE_MSUBU_OP = 8'b1010_1011;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_ZERO = 2'd1,
    DIV_ON   = 2'd2,
    DIV_END  = 2'd3
  } div_state_t;

  div_state_t  state;
  logic [31:0] hi, lo;
  logic [31:0] quot, rem, divisor;
  logic [4:0]  count;
  logic        q_neg, r_neg, div_zero;
  logic        madd_phase, busy;
  logic [63:0] prod_q;

  logic        is_div, is_sdiv, is_madd, is_msub, is_smadd;
  logic [63:0] sprod, uprod, hilo_acc;
  logic [32:0] rem_shift, rem_sub;
  logic [31:0] dividend_mag, divisor_mag;

  always_comb begin
    is_div   = (bus.aluop_i == EXE_DIV_OP) || (bus.aluop_i == EXE_DIVU_OP);
    is_sdiv  = (bus.aluop_i == EXE_DIV_OP);
    is_madd  = (bus.aluop_i == EXE_MADD_OP) || (bus.aluop_i == EXE_MADDU_OP) ||
               (bus.aluop_i == EXE_MSUB_OP) || (bus.aluop_i == EXE_MSUBU_OP);
    is_msub  = (bus.aluop_i == EXE_MSUB_OP) || (bus.aluop_i == EXE_MSUBU_OP);
    is_smadd = (bus.aluop_i == EXE_MADD_OP) || (bus.aluop_i == EXE_MSUB_OP);
    sprod    = 64'($signed({{32{bus.reg1_i[31]}}, bus.reg1_i}) *
                   $signed({{32{bus.reg2_i[31]}}, bus.reg2_i}));
    uprod    = {32'd0, bus.reg1_i} * {32'd0, bus.reg2_i};
    hilo_acc = is_msub ? ({hi, lo} - prod_q) : ({hi, lo} + prod_q);
    // One restoring step: shift the next dividend bit in, subtract if it fits
    rem_shift    = {rem, quot[31]};
    rem_sub      = rem_shift - {1'b0, divisor};
    dividend_mag = (is_sdiv && bus.reg1_i[31]) ? (32'd0 - bus.reg1_i) : bus.reg1_i;
    divisor_mag  = (is_sdiv && bus.reg2_i[31]) ? (32'd0 - bus.reg2_i) : bus.reg2_i;
  end

  assign bus.stallreq_o = bus.valid_i & ~bus.flush_i &
                          ((is_madd & ~madd_phase) | (is_div & (state != DIV_END)));
  assign bus.hi_o       = hi;
  assign bus.lo_o       = lo;
  assign bus.busy_o     = busy;
  assign bus.div_state  = state;
  assign bus.madd_phase = madd_phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      hi         <= '0;
      lo         <= '0;
      quot       <= '0;
      rem        <= '0;
      divisor    <= '0;
      count      <= '0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      div_zero   <= 1'b0;
      madd_phase <= 1'b0;
      prod_q     <= '0;
    end else if (bus.flush_i) begin
      state      <= IDLE;
      busy       <= 1'b0;
      madd_phase <= 1'b0;
    end else begin
      if (madd_phase) begin
        madd_phase <= 1'b0;
        if (bus.valid_i && is_madd) {hi, lo} <= hilo_acc;
      end else if (bus.valid_i && is_madd) begin
        prod_q     <= is_smadd ? sprod : uprod;
        madd_phase <= 1'b1;
      end

      if (bus.valid_i) begin
        case (bus.aluop_i)
          EXE_MTHI_OP:  hi <= bus.reg1_i;
          EXE_MTLO_OP:  lo <= bus.reg1_i;
          EXE_MULT_OP:  {hi, lo} <= sprod;
          EXE_MULTU_OP: {hi, lo} <= uprod;
          default: ;
        endcase
      end

      case (state)
        IDLE: begin
          if (bus.valid_i && is_div) begin
            busy     <= 1'b1;
            div_zero <= (bus.reg2_i == 32'd0);
            state    <= (bus.reg2_i == 32'd0) ? DIV_ZERO : DIV_ON;
            quot     <= dividend_mag;
            rem      <= '0;
            divisor  <= divisor_mag;
            count    <= '0;
            q_neg    <= is_sdiv & (bus.reg1_i[31] ^ bus.reg2_i[31]);
            r_neg    <= is_sdiv & bus.reg1_i[31];
          end
        end
        DIV_ZERO: state <= DIV_END;
        DIV_ON: begin
          if (!rem_sub[32]) begin
            rem  <= rem_sub[31:0];
            quot <= {quot[30:0], 1'b1};
          end else begin
            rem  <= rem_shift[31:0];
            quot <= {quot[30:0], 1'b0};
          end
          count <= count + 5'd1;
          if (count == 5'd31) state <= DIV_END;
        end
        DIV_END: begin
          if (!div_zero) begin
            lo <= q_neg ? (32'd0 - quot) : quot;
            hi <= r_neg ? (32'd0 - rem) : rem;
          end
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_hilo.sv
// Self-checking bench for muldiv_hilo: randomized ops against an arithmetic HI/LO model.
module tb_muldiv_hilo;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;
  localparam logic [7:0] EXE_MADD_OP  = 8'b1010_0110;
  localparam logic [7:0] EXE_MADDU_OP = 8'b1010_1000;
  localparam logic [7:0] EXE_MSUB_OP  = 8'b1010_1010;
  localparam logic [7:0] EXE_MSUBU_OP = 8'b1010_1011;
  localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_hilo_if bus ();
  muldiv_hilo dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [31:0] hi_m, lo_m;

  // Reference model: architectural effect of one op; returns expected stall cycles
  function automatic int model_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint sa, sb, q, r;
    case (op)
      EXE_MTHI_OP: begin hi_m = a; return 0; end
      EXE_MTLO_OP: begin lo_m = a; return 0; end
      EXE_MULT_OP: begin
        p = 64'(longint'($signed(a)) * longint'($signed(b)));
        {hi_m, lo_m} = p; return 0;
      end
      EXE_MULTU_OP: begin
        p = {32'd0, a} * {32'd0, b};
        {hi_m, lo_m} = p; return 0;
      end
      EXE_MADD_OP, EXE_MADDU_OP, EXE_MSUB_OP, EXE_MSUBU_OP: begin
        if (op == EXE_MADD_OP || op == EXE_MSUB_OP) p = 64'(longint'($signed(a)) * longint'($signed(b)));
        else p = {32'd0, a} * {32'd0, b};
        if (op == EXE_MSUB_OP || op == EXE_MSUBU_OP) {hi_m, lo_m} = {hi_m, lo_m} - p;
        else {hi_m, lo_m} = {hi_m, lo_m} + p;
        return 1;
      end
      EXE_DIV_OP: begin
        if (b == 32'd0) return 2;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q = sa / sb;
        r = sa % sb;
        lo_m = q[31:0];
        hi_m = r[31:0];
        return 33;
      end
      EXE_DIVU_OP: begin
        if (b == 32'd0) return 2;
        lo_m = a / b;
        hi_m = a % b;
        return 33;
      end
      default: return 0;
    endcase
  endfunction

  // driver tasks: called just after a rising edge
  task automatic idle();
    bus.valid_i = 1'b0;
    bus.aluop_i = 8'd0;
    bus.flush_i = 1'b0;
  endtask

  task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b, output int stalls);
    bus.valid_i = 1'b1;
    bus.aluop_i = op;
    bus.reg1_i  = a;
    bus.reg2_i  = b;
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.stallreq_o) break;
      stalls++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (bus.hi_o !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h expected %h", bus.hi_o, 32'd0); end
    checks++; if (bus.lo_o !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h expected %h", bus.lo_o, 32'd0); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy_o); end
    checks++; if (bus.stallreq_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", bus.stallreq_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_mult();
    logic [7:0] ops [5];
    logic [7:0] op;
    logic [31:0] a, b;
    int exp_st, st;
    ops = '{EXE_MTHI_OP, EXE_MTLO_OP, EXE_MULT_OP, EXE_MULTU_OP, EXE_AND_OP};
    for (int i = 0; i < 24; i++) begin
      if (i == 0) begin op = EXE_MULT_OP; a = 32'hFFFF_FFFF; b = 32'd2; end
      else if (i == 1) begin op = EXE_MULTU_OP; a = 32'hFFFF_FFFF; b = 32'd2; end
      else begin op = ops[$urandom_range(0, 4)]; a = $urandom; b = $urandom; end
      exp_st = model_op(op, a, b);
      run_op(op, a, b, st);
      idle();
      checks++; if (st !== exp_st) begin errors++; $display("FAIL mult_stall op=%h: got %0d expected %0d", op, st, exp_st); end
      checks++; if (bus.hi_o !== hi_m) begin errors++; $display("FAIL mult_hi op=%h a=%h b=%h: got %h expected %h", op, a, b, bus.hi_o, hi_m); end
      checks++; if (bus.lo_o !== lo_m) begin errors++; $display("FAIL mult_lo op=%h a=%h b=%h: got %h expected %h", op, a, b, bus.lo_o, lo_m); end
    end
  endtask

  task automatic test_madd();
    logic [7:0] ops [6];
    logic [7:0] op;
    logic [31:0] a, b;
    int exp_st, st;
    ops = '{EXE_MADD_OP, EXE_MADDU_OP, EXE_MSUB_OP, EXE_MSUBU_OP, EXE_MTHI_OP, EXE_MTLO_OP};
    for (int i = 0; i < 25; i++) begin
      case (i)
        0: begin op = EXE_MTLO_OP;  a = 32'd5; b = 32'd0; end
        1: begin op = EXE_MTHI_OP;  a = 32'd0; b = 32'd0; end
        2: begin op = EXE_MADD_OP;  a = 32'd3; b = 32'd4; end
        3: begin op = EXE_MSUBU_OP; a = 32'd10; b = 32'd1; end
        4: begin op = EXE_MSUB_OP;  a = 32'd1; b = 32'd8; end
        default: begin op = ops[$urandom_range(0, 5)]; a = $urandom; b = $urandom; end
      endcase
      exp_st = model_op(op, a, b);
      run_op(op, a, b, st);
      idle();
      checks++; if (st !== exp_st) begin errors++; $display("FAIL madd_stall op=%h: got %0d expected %0d", op, st, exp_st); end
      checks++; if (bus.hi_o !== hi_m) begin errors++; $display("FAIL madd_hi op=%h a=%h b=%h: got %h expected %h", op, a, b, bus.hi_o, hi_m); end
      checks++; if (bus.lo_o !== lo_m) begin errors++; $display("FAIL madd_lo op=%h a=%h b=%h: got %h expected %h", op, a, b, bus.lo_o, lo_m); end
    end
  endtask

  task automatic test_div();
    logic [7:0] op;
    logic [31:0] a, b;
    int exp_st, st;
    for (int i = 0; i < 18; i++) begin
      case (i)
        0: begin op = EXE_DIV_OP;  a = 32'hFFFF_FFF9; b = 32'd2; end
        1: begin op = EXE_DIVU_OP; a = 32'd100; b = 32'd7; end
        2: begin op = EXE_DIV_OP;  a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: begin op = EXE_MTHI_OP; a = 32'h11; b = 32'd0; end
        4: begin op = EXE_MTLO_OP; a = 32'h22; b = 32'd0; end
        5: begin op = EXE_DIV_OP;  a = 32'd1234; b = 32'd0; end
        6: begin op = EXE_DIVU_OP; a = $urandom; b = 32'd0; end
        default: begin
          op = ($urandom_range(0, 1) == 0) ? EXE_DIV_OP : EXE_DIVU_OP;
          a = $urandom;
          b = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(1, 16);
          if ($urandom_range(0, 1) == 0) b = 32'd0 - b;
          if (b == 32'd0) b = 32'd3;
        end
      endcase
      exp_st = model_op(op, a, b);
      run_op(op, a, b, st);
      idle();
      checks++; if (st !== exp_st) begin errors++; $display("FAIL div_stall op=%h b=%h: got %0d expected %0d", op, b, st, exp_st); end
      checks++; if (bus.hi_o !== hi_m) begin errors++; $display("FAIL div_hi op=%h a=%h b=%h: got %h expected %h", op, a, b, bus.hi_o, hi_m); end
      checks++; if (bus.lo_o !== lo_m) begin errors++; $display("FAIL div_lo op=%h a=%h b=%h: got %h expected %h", op, a, b, bus.lo_o, lo_m); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a0, b0, a1, b1, hi0, lo0;
    int e0, e1, s0, s1;
    a0 = $urandom; b0 = $urandom_range(1, 1000);
    a1 = $urandom; b1 = 32'd0 - 32'($urandom_range(1, 50));
    e0 = model_op(EXE_DIVU_OP, a0, b0);
    hi0 = hi_m; lo0 = lo_m;
    e1 = model_op(EXE_DIV_OP, a1, b1);
    run_op(EXE_DIVU_OP, a0, b0, s0);
    checks++; if (bus.hi_o !== hi0 || bus.lo_o !== lo0) begin errors++; $display("FAIL b2b_first: got %h/%h expected %h/%h", bus.hi_o, bus.lo_o, hi0, lo0); end
    run_op(EXE_DIV_OP, a1, b1, s1);
    idle();
    checks++; if (s0 !== e0 || s1 !== e1) begin errors++; $display("FAIL b2b_stall: got %0d/%0d expected %0d/%0d", s0, s1, e0, e1); end
    checks++; if (bus.hi_o !== hi_m || bus.lo_o !== lo_m) begin errors++; $display("FAIL b2b_second: got %h/%h expected %h/%h", bus.hi_o, bus.lo_o, hi_m, lo_m); end
  endtask

  task automatic test_flush_div();
    int st, exp_st;
    logic [31:0] a, b;
    run_op(EXE_MTHI_OP, $urandom, 32'd0, st); hi_m = bus.hi_o;
    run_op(EXE_MTLO_OP, 32'h5A5A_0001, 32'd0, st); lo_m = 32'h5A5A_0001;
    bus.valid_i = 1'b1; bus.aluop_i = EXE_DIV_OP; bus.reg1_i = 32'd999; bus.reg2_i = 32'd5;
    repeat (10) @(posedge clk);
    #1 bus.flush_i = 1'b1;
    @(negedge clk);
    checks++; if (bus.stallreq_o !== 1'b0) begin errors++; $display("FAIL flush_div_stall_during: got %b expected 0", bus.stallreq_o); end
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    checks++; if (bus.div_state !== 2'd0) begin errors++; $display("FAIL flush_div_state: got %0d expected 0", bus.div_state); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL flush_div_busy: got %b expected 0", bus.busy_o); end
    checks++; if (bus.stallreq_o !== 1'b0) begin errors++; $display("FAIL flush_div_stall: got %b expected 0", bus.stallreq_o); end
    checks++; if (bus.hi_o !== hi_m || bus.lo_o !== lo_m) begin errors++; $display("FAIL flush_div_hilo: got %h/%h expected %h/%h", bus.hi_o, bus.lo_o, hi_m, lo_m); end
    // A later divide must start from a clean state
    @(posedge clk); #1;
    a = $urandom; b = $urandom_range(1, 9999);
    exp_st = model_op(EXE_DIV_OP, a, b);
    run_op(EXE_DIV_OP, a, b, st);
    idle();
    checks++; if (st !== exp_st || bus.hi_o !== hi_m || bus.lo_o !== lo_m) begin errors++; $display("FAIL flush_div_after: got %0d %h/%h expected %0d %h/%h", st, bus.hi_o, bus.lo_o, exp_st, hi_m, lo_m); end
  endtask

  task automatic test_flush_madd();
    bus.valid_i = 1'b1; bus.aluop_i = EXE_MADD_OP; bus.reg1_i = 32'd7; bus.reg2_i = 32'd9;
    bus.flush_i = 1'b1;
    @(negedge clk);
    checks++; if (bus.stallreq_o !== 1'b0) begin errors++; $display("FAIL flush_madd_stall: got %b expected 0", bus.stallreq_o); end
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    checks++; if (bus.madd_phase !== 1'b0) begin errors++; $display("FAIL flush_madd_phase: got %b expected 0", bus.madd_phase); end
    @(posedge clk); #1;
    checks++; if (bus.hi_o !== hi_m || bus.lo_o !== lo_m) begin errors++; $display("FAIL flush_madd_hilo: got %h/%h expected %h/%h", bus.hi_o, bus.lo_o, hi_m, lo_m); end
    // Flush in the accumulate cycle also suppresses the write
    bus.valid_i = 1'b1; bus.aluop_i = EXE_MSUBU_OP; bus.reg1_i = 32'd3; bus.reg2_i = 32'd3;
    @(posedge clk); #1;
    bus.flush_i = 1'b1;
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    checks++; if (bus.hi_o !== hi_m || bus.lo_o !== lo_m) begin errors++; $display("FAIL flush_madd_p2_hilo: got %h/%h expected %h/%h", bus.hi_o, bus.lo_o, hi_m, lo_m); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_div();
    int st;
    run_op(EXE_MTHI_OP, 32'hDEAD_BEEF, 32'd0, st);
    run_op(EXE_MTLO_OP, 32'hCAFE_F00D, 32'd0, st);
    bus.valid_i = 1'b1; bus.aluop_i = EXE_DIVU_OP; bus.reg1_i = 32'd50000; bus.reg2_i = 32'd3;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle();
    hi_m = 32'd0; lo_m = 32'd0;
    @(negedge clk);
    checks++; if (bus.hi_o !== hi_m) begin errors++; $display("FAIL rst_div_hi: got %h expected %h", bus.hi_o, hi_m); end
    checks++; if (bus.lo_o !== lo_m) begin errors++; $display("FAIL rst_div_lo: got %h expected %h", bus.lo_o, lo_m); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL rst_div_busy: got %b expected 0", bus.busy_o); end
    checks++; if (bus.stallreq_o !== 1'b0) begin errors++; $display("FAIL rst_div_stall: got %b expected 0", bus.stallreq_o); end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.reg1_i = '0;
    bus.reg2_i = '0;
    idle();
    hi_m = '0;
    lo_m = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_mult();
    test_madd();
    test_div();
    test_back_to_back();
    test_flush_div();
    test_flush_madd();
    test_reset_div();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_hilo.md
# muldiv_hilo

Multiply/divide and HI/LO unit in the execute stage. It consumes the decoded `aluop`, `reg1` and `reg2` operands produced by instruction decode and owns the architectural HI and LO registers. It executes MULT/MULTU, the MADD/MSUB family, DIV/DIVU and MTHI/MTLO, and asserts a stall request while a multi-cycle operation is in flight.

## Interface
- DATA_W, 32, operand and HI/LO width. Only 32 is supported.
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- valid_i  in  1  an instruction is present in EX this cycle
- aluop_i  in  8  decoded ALU op, using the shared EXE_*_OP codes
- reg1_i  in  32  operand 1 (rs, after forwarding)
- reg2_i  in  32  operand 2 (rt, after forwarding)
- flush_i  in  1  annul the in-flight operation (exception/branch flush)
- hi_o  out  32  architectural HI (registered)
- lo_o  out  32  architectural LO (registered)
- stallreq_o  out  1  request to freeze PC/IF/ID/EX (combinational)
- busy_o  out  1  state != IDLE (registered)

## Operation
- Upstream holds valid_i, aluop_i, reg1_i and reg2_i stable while stallreq_o=1.
- Ops other than those below are ignored. Ignored ops leave HI/LO untouched and keep stallreq_o=0.
- MTHI / MTLO: HI or LO takes reg1_i at the next edge. No stall.
- MULT / MULTU: {HI,LO} takes the signed or unsigned 32x32 -> 64-bit product at the next edge. No stall.
- MADD / MADDU / MSUB / MSUBU: two-cycle operation.
  - Phase 1: register the product (signed for MADD/MSUB, unsigned for MADDU/MSUBU); stallreq_o=1.
  - Phase 2: {HI,LO} takes {HI,LO} ± product, mod 2^64; stallreq_o=0.
- DIV / DIVU: FSM with states IDLE, DIV_ZERO, DIV_ON, DIV_END.
  - IDLE, div op with reg2_i=0 -> DIV_ZERO. IDLE, div op with reg2_i≠0 -> DIV_ON; load |dividend|, |divisor| and count=0.
  - DIV_ON: one restoring shift-subtract step per cycle. When count reaches 31 the step completes and the FSM goes to DIV_END (32 steps total).
  - DIV_ZERO -> DIV_END with no result.
  - DIV_END: commit LO=quotient and HI=remainder, except after DIV_ZERO, where HI/LO are unchanged. Then -> IDLE.
- Signed divide works on magnitudes. The quotient is negated if the operand signs differ. The remainder takes the dividend's sign.
- Signed divide boundary: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- flush_i has priority over everything except rst. At the next edge it returns the FSM and MADD phase to IDLE, and no HI/LO write occurs in that cycle.
- rst has priority over all other inputs.
- Reset values: hi_o=0, lo_o=0, busy_o=0, stallreq_o=0, FSM=IDLE, MADD phase=0.

## Timing
- HI/LO writes land at the rising edge ending the issuing cycle (or the final cycle for multi-cycle ops). The new value is visible on hi_o/lo_o in the following cycle.
- stallreq_o = valid_i & ~flush_i & (MADD-family op in phase 1, or div op with FSM ≠ DIV_END).
- MADD family: stall 1 cycle; total 2 cycles.
- DIV (nonzero divisor): stallreq_o is high for 33 cycles (issue cycle plus 32 DIV_ON cycles). DIV_END is cycle 34, with stallreq_o=0; the commit lands at the end of that cycle.
- DIV by zero: stall 2 cycles (IDLE, DIV_ZERO). DIV_END is cycle 3, with no write.
- Back-to-back: a div op presented the cycle after DIV_END starts a new divide from IDLE.
- busy_o tracks the registered FSM state and lags stallreq_o by one cycle at issue.

## Test plan
- Reset: assert rst for 2 cycles during an active divide -> hi_o=lo_o=0, busy_o=0, stallreq_o=0 after the edge.
- MULT: reg1=0xFFFFFFFF, reg2=2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE, no stall. MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- MADD / MSUBU:
  - After MTLO 5 and MTHI 0, MADD 3,4 -> stallreq_o high 1 cycle, then HI=0, LO=17.
  - Then MSUBU 10,1 -> LO=7.
  - Then MSUB 1,8 with HI=0, LO=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFFF.
- Divide results and stall lengths:
  - DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF, stallreq_o high exactly 33 cycles.
  - DIVU 100/7 -> LO=14, HI=2.
  - DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIV by zero with HI=0x11, LO=0x22 -> stallreq_o high 2 cycles; HI/LO remain 0x11/0x22.
- Flush:
  - Assert flush_i in DIV_ON cycle 10 -> FSM IDLE next cycle, stallreq_o=0, HI/LO unchanged.
  - Assert flush_i in MADD phase 1 -> no accumulate.
